// File: rtl/mips32_mem_resp.sv
// Purpose : word-addressed DEPTH x 32 memory slave for a pipeline core's load/store/fetch traffic.
// Latency : LATENCY+1 cycles from request acceptance to rsp_valid (1 cycle when LATENCY=0).
// Backpr. : one transaction in flight; req_ready low until the response handshakes, rsp held while rsp_ready low.
//
// Ports:
//   i_clk, i_rst_n                          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready                 request handshake
//   i_req_we, i_req_addr, i_req_wdata       1=store/0=load, word address, store data
//   o_rsp_valid/i_rsp_ready                 response handshake
//   o_rsp_rdata, o_rsp_err                  load data (0 for stores/errors), out-of-range flag
//   o_busy                                  transaction in flight
module mips32_mem_resp #(
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_busy
);

   localparam int  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit  ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;
   logic                r_busy;
   logic [31:0]         r_mem [DEPTH];

   // With zero wait states the commit happens on the accepting edge itself,
   // so the commit operands come straight from the request port in IDLE.
   logic                w_in_idle;
   logic                w_c_we;
   logic [ADDR_W-1:0]   w_c_addr;
   logic [31:0]         w_c_wdata;
   logic                w_oor;
   logic [IDX_W-1:0]    w_idx;
   logic                w_commit;

   assign w_in_idle = (r_state == IDLE);
   assign w_c_we    = w_in_idle ? i_req_we    : r_we;
   assign w_c_addr  = w_in_idle ? i_req_addr  : r_addr;
   assign w_c_wdata = w_in_idle ? i_req_wdata : r_wdata;

   // Full-width range check; an address with stray high bits must not alias.
   assign w_oor = (64'(w_c_addr) >= 64'(DEPTH));
   assign w_idx = w_c_addr[IDX_W-1:0];

   assign w_commit = (w_in_idle && i_req_valid && ZERO_LAT) ||
                     ((r_state == WAIT) && (r_cnt == 4'd1));

   // Array has no reset; the write is suppressed while reset is asserted so an
   // abandoned transaction can never reach the array.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_commit && w_c_we && !w_oor) begin
         r_mem[w_idx] <= w_c_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // Response payload update shared by the IDLE (zero-latency) and WAIT commit paths.
         if (w_commit) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            if (w_oor) begin
               r_rsp_err   <= 1'b1;
               r_rsp_rdata <= 32'd0;
            end else if (w_c_we) begin
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= 32'd0;
            end else begin
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= r_mem[w_idx];
            end
         end

         case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  r_we        <= i_req_we;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  r_cnt       <= 4'(LATENCY);
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (!ZERO_LAT) begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
            end
            RESP: begin
               if (i_rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= 32'd0;
                  r_rsp_err   <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready = r_req_ready;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_mips32_mem_resp.sv
// Purpose : directed bench for mips32_mem_resp (LATENCY=2 and LATENCY=0 instances).
// Latency : checks LATENCY+1 response latency and the 2-cycle zero-latency stream period.
// Backpr. : exercises a 10-cycle rsp_ready stall with request noise on the input port.
module tb_mips32_mem_resp;

   logic        clk = 1'b0;
   logic        rst_n;

   // LATENCY=2 instance
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] req_addr, req_wdata, rsp_rdata;

   // LATENCY=0 instance
   logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
   logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mips32_mem_resp #(.DEPTH(1024), .ADDR_W(32), .LATENCY(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy)
   );

   mips32_mem_resp #(.DEPTH(1024), .ADDR_W(32), .LATENCY(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(z_req_valid), .o_req_ready(z_req_ready), .i_req_we(z_req_we),
      .i_req_addr(z_req_addr), .i_req_wdata(z_req_wdata),
      .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready),
      .o_rsp_rdata(z_rsp_rdata), .o_rsp_err(z_rsp_err), .o_busy(z_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // One complete transaction on the LATENCY=2 instance with rsp_ready high.
   task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      int low;
      @(negedge clk);
      chk($sformatf("%s/idle_ready", nm), 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
      @(negedge clk);
      // Scramble the port after acceptance; the latched request must win.
      req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
      lat = 1;
      low = 0;
      while (!rsp_valid && lat < 40) begin
         if (!req_ready) low++;
         @(negedge clk);
         lat++;
      end
      if (!req_ready) low++;
      chk($sformatf("%s/latency", nm), 32'(lat), 32'd3);
      chk($sformatf("%s/ready_low_cycles", nm), 32'(low), 32'd3);
      chk($sformatf("%s/busy", nm), 32'(busy), 32'd1);
      chk($sformatf("%s/rdata", nm), rsp_rdata, exp_rdata);
      chk($sformatf("%s/err", nm), 32'(rsp_err), 32'(exp_err));
      @(negedge clk);
      chk($sformatf("%s/post_valid", nm), 32'(rsp_valid), 32'd0);
      chk($sformatf("%s/post_ready", nm), 32'(req_ready), 32'd1);
      chk($sformatf("%s/post_rdata", nm), rsp_rdata, 32'd0);
      chk($sformatf("%s/post_busy", nm), 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 10;
   vec_t        vecs [NVEC];

   int          nxt, nrsp, last, first;
   logic [31:0] got [3];

   initial begin
      vecs[0] = '{1'b0, 32'd5,          32'd0,          32'h0000_00AA, 1'b0};
      vecs[1] = '{1'b1, 32'd100,        32'hDEAD_BEEF,  32'd0,         1'b0};
      vecs[2] = '{1'b0, 32'd100,        32'd0,          32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b0, 32'd1024,       32'd0,          32'd0,         1'b1};
      vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'h0000_0BAD,  32'd0,         1'b1};
      vecs[5] = '{1'b0, 32'd0,          32'd0,          32'h1111_0000, 1'b0};
      vecs[6] = '{1'b0, 32'd1023,       32'd0,          32'h2222_FFFF, 1'b0};
      vecs[7] = '{1'b0, 32'h0001_0005,  32'd0,          32'd0,         1'b1};
      vecs[8] = '{1'b1, 32'd1023,       32'h5A5A_5A5A,  32'd0,         1'b0};
      vecs[9] = '{1'b0, 32'd1023,       32'd0,          32'h5A5A_5A5A, 1'b0};

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_rsp_ready = 1'b0;

      #3;
      chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset/busy", 32'(busy), 32'd0);
      chk("reset/rdata", rsp_rdata, 32'd0);

      dut.r_mem[0]    = 32'h1111_0000;
      dut.r_mem[5]    = 32'h0000_00AA;
      dut.r_mem[7]    = 32'h0000_0077;
      dut.r_mem[100]  = 32'd0;
      dut.r_mem[1023] = 32'h2222_FFFF;
      dut0.r_mem[0]   = 32'h0000_00C0;
      dut0.r_mem[1]   = 32'h0000_00C1;
      dut0.r_mem[2]   = 32'h0000_00C2;

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset/req_ready", 32'(req_ready), 32'd1);
      chk("post_reset/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_reset/rdata", rsp_rdata, 32'd0);
      chk("post_reset/err", 32'(rsp_err), 32'd0);
      chk("post_reset/busy", 32'(busy), 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);
      end

      // Response stall with request-port noise.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
      chk("stall/rsp_valid_rise", 32'(rsp_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         req_valid = k[0];
         req_we    = k[1];
         req_addr  = 32'(k * 3);
         req_wdata = 32'(k);
         @(negedge clk);
         chk($sformatf("stall%0d/rdata", k), rsp_rdata, 32'h0000_00AA);
         chk($sformatf("stall%0d/req_ready", k), 32'(req_ready), 32'd0);
         chk($sformatf("stall%0d/rsp_valid", k), 32'(rsp_valid), 32'd1);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall/release_valid", 32'(rsp_valid), 32'd0);
      chk("stall/release_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("stall/no_second_txn", 32'(busy), 32'd0);

      // Reset while the store to address 7 is waiting.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h0000_1234; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("midwait/busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midwait/rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midwait/rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midwait/req_ready", 32'(req_ready), 32'd1);
      chk("midwait/busy_after", 32'(busy), 32'd0);
      txn("midwait_rd7", 1'b0, 32'd7, 32'd0, 32'h0000_0077, 1'b0);

      // Zero-latency instance streaming addresses 0,1,2.
      nxt = 0; nrsp = 0; last = -1; first = -1;
      z_rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (z_rsp_valid) begin
            if (nrsp < 3) got[nrsp] = z_rsp_rdata;
            if (last >= 0) chk($sformatf("lat0/gap%0d", nrsp), 32'(c - last), 32'd2);
            else first = c;
            last = c;
            nrsp++;
         end
         if (z_req_ready) begin
            if (nxt < 3) begin
               z_req_valid = 1'b1;
               z_req_addr  = 32'(nxt);
               nxt++;
            end else begin
               z_req_valid = 1'b0;
            end
         end
      end
      chk("lat0/first_latency", 32'(first), 32'd1);
      chk("lat0/count", 32'(nrsp), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lat0/rdata%0d", i), got[i], 32'h0000_00C0 + 32'(i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
